kernel_sequencer: RTL

- Parametrised next-generation instruction sequencer for the cherry core: fetches kernel instructions from instruction memory, decodes them and issues memory and processing instructions to downstream queues.
- Uses ready/valid backpressure to those queues and an internal nested loop stack of configurable depth.
- Adds kernel start/done sequencing and sticky error reporting.
- Sits between the instruction memory and the APU memory/processing instruction queues.

---
 rtl/kernel_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/kernel_sequencer.sv
// kernel_sequencer: fetches kernel instructions from instruction memory,
// decodes them and issues memory/processing instructions to ready/valid
// queues. Supports nested loops, start/done sequencing and sticky errors.
// Instruction data arrives one cycle after pc is presented, so FETCH covers
// the memory latency and ISSUE decodes the returned word directly.
module kernel_sequencer #(
    parameter int ISA_WIDTH      = 18,
    parameter int ADDR_WIDTH     = 18,
    parameter int LOOP_DEPTH_LOG = 3,
    parameter int COUNT_WIDTH    = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   kernel_start_pc,
    output logic [ADDR_WIDTH-1:0]   pc,
    input  logic [ISA_WIDTH-1:0]    raw_instruction,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [15:0]             mem_payload,
    output logic                    proc_valid,
    input  logic                    proc_ready,
    output logic [15:0]             proc_payload,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              error_code,
    output logic [LOOP_DEPTH_LOG:0] loop_depth
);
    localparam int LOOP_DEPTH = 2 ** LOOP_DEPTH_LOG;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    localparam logic [1:0] T_MEM  = 2'b00;
    localparam logic [1:0] T_PROC = 2'b01;
    localparam logic [1:0] T_LOOP = 2'b10;

    localparam logic [1:0] L_START = 2'b00;
    localparam logic [1:0] L_END   = 2'b01;
    localparam logic [1:0] L_HALT  = 2'b10;

    localparam logic [1:0] E_ILLEGAL  = 2'b01;
    localparam logic [1:0] E_OVERFLOW = 2'b10;
    localparam logic [1:0] E_LOOP     = 2'b11;

    localparam logic [LOOP_DEPTH_LOG:0]   DEPTH_ONE  = (LOOP_DEPTH_LOG + 1)'(1);
    localparam logic [LOOP_DEPTH_LOG:0]   DEPTH_FULL = (LOOP_DEPTH_LOG + 1)'(LOOP_DEPTH);
    localparam logic [LOOP_DEPTH_LOG-1:0] IDX_ONE    = LOOP_DEPTH_LOG'(1);
    localparam logic [COUNT_WIDTH-1:0]    COUNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]     PC_ONE     = ADDR_WIDTH'(1);

    logic [1:0]                state, state_next;
    logic [ADDR_WIDTH-1:0]     pc_next, pc_inc;
    logic [LOOP_DEPTH_LOG:0]   depth_next;
    logic [1:0]                code_next;
    logic                      push_en, dec_en, clear_en;

    logic [ADDR_WIDTH-1:0]     body_pc_stack   [LOOP_DEPTH];
    logic [COUNT_WIDTH-1:0]    remaining_stack [LOOP_DEPTH];

    logic [1:0]                instr_type, loop_op;
    logic [COUNT_WIDTH-1:0]    count;
    logic [LOOP_DEPTH_LOG-1:0] top_idx, push_idx;
    logic [ADDR_WIDTH-1:0]     top_body_pc;
    logic [COUNT_WIDTH-1:0]    top_remaining;
    logic                      stack_empty, stack_full, issuing;

    // Bits above the fixed 18-bit format carry no meaning.
    if (ISA_WIDTH > 18) begin : g_wide_isa
        logic unused_upper;
        assign unused_upper = ^raw_instruction[ISA_WIDTH-1:18];
    end

    assign instr_type    = raw_instruction[17:16];
    assign loop_op       = raw_instruction[15:14];
    assign count         = raw_instruction[COUNT_WIDTH-1:0];
    assign pc_inc        = pc + PC_ONE;
    assign push_idx      = loop_depth[LOOP_DEPTH_LOG-1:0];
    assign top_idx       = loop_depth[LOOP_DEPTH_LOG-1:0] - IDX_ONE;
    assign top_body_pc   = body_pc_stack[top_idx];
    assign top_remaining = remaining_stack[top_idx];
    assign stack_empty   = (loop_depth == '0);
    assign stack_full    = (loop_depth == DEPTH_FULL);
    assign issuing       = (state == S_ISSUE);

    // Outputs are decoded from the registered state and the stable memory word;
    // pc does not move during ISSUE, so valid and payload hold under backpressure.
    assign mem_valid    = issuing && (instr_type == T_MEM);
    assign proc_valid   = issuing && (instr_type == T_PROC);
    assign mem_payload  = mem_valid  ? raw_instruction[15:0] : 16'h0000;
    assign proc_payload = proc_valid ? raw_instruction[15:0] : 16'h0000;
    assign done         = issuing && (instr_type == T_LOOP) && (loop_op == L_HALT);
    assign busy         = (state != S_IDLE);
    assign error        = (state == S_ERROR);

    // Next-state, next-pc and loop stack control decode.
    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that left
        // one unassigned would infer a latch.
        state_next = state;
        pc_next    = pc;
        depth_next = loop_depth;
        code_next  = error_code;
        push_en    = 1'b0;
        dec_en     = 1'b0;
        clear_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    pc_next    = kernel_start_pc;
                    depth_next = '0;
                    clear_en   = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: state_next = S_ISSUE;
            S_ISSUE: begin
                case (instr_type)
                    T_MEM: begin
                        if (mem_ready) begin
                            pc_next    = pc_inc;
                            state_next = S_FETCH;
                        end
                    end
                    T_PROC: begin
                        if (proc_ready) begin
                            pc_next    = pc_inc;
                            state_next = S_FETCH;
                        end
                    end
                    T_LOOP: begin
                        case (loop_op)
                            L_START: begin
                                // Overflow outranks a zero count.
                                if (stack_full) begin
                                    code_next  = E_OVERFLOW;
                                    state_next = S_ERROR;
                                end else if (count == '0) begin
                                    code_next  = E_LOOP;
                                    state_next = S_ERROR;
                                end else begin
                                    push_en    = 1'b1;
                                    depth_next = loop_depth + DEPTH_ONE;
                                    pc_next    = pc_inc;
                                    state_next = S_FETCH;
                                end
                            end
                            L_END: begin
                                if (stack_empty || (top_remaining == '0)) begin
                                    code_next  = E_LOOP;
                                    state_next = S_ERROR;
                                end else if (top_remaining > COUNT_ONE) begin
                                    dec_en     = 1'b1;
                                    pc_next    = top_body_pc;
                                    state_next = S_FETCH;
                                end else begin
                                    depth_next = loop_depth - DEPTH_ONE;
                                    pc_next    = pc_inc;
                                    state_next = S_FETCH;
                                end
                            end
                            L_HALT: begin
                                depth_next = '0;
                                clear_en   = 1'b1;
                                state_next = S_IDLE;
                            end
                            default: begin
                                code_next  = E_ILLEGAL;
                                state_next = S_ERROR;
                            end
                        endcase
                    end
                    default: begin
                        code_next  = E_ILLEGAL;
                        state_next = S_ERROR;
                    end
                endcase
            end
            S_ERROR: state_next = S_ERROR;
        endcase
    end

    // Control registers and loop stack update.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            state      <= S_IDLE;
            pc         <= '0;
            loop_depth <= '0;
            error_code <= 2'b00;
            // NOTE: the loop stack is small and must read as empty after reset,
            // so it is cleared here rather than left as uninitialised storage.
            for (int i = 0; i < LOOP_DEPTH; i++) begin
                body_pc_stack[i]   <= '0;
                remaining_stack[i] <= '0;
            end
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            loop_depth <= depth_next;
            error_code <= code_next;
            if (clear_en) begin
                for (int i = 0; i < LOOP_DEPTH; i++) begin
                    body_pc_stack[i]   <= '0;
                    remaining_stack[i] <= '0;
                end
            end else if (push_en) begin
                body_pc_stack[push_idx]   <= pc_inc;
                remaining_stack[push_idx] <= count;
            end else if (dec_en) begin
                remaining_stack[top_idx] <= top_remaining - COUNT_ONE;
            end
        end
    end

endmodule
